// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR and its period monitor.
package lfsr_pkg;

  localparam int LFSR_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    COUNT,
    DONE,
    LOCKUP,
    TIMEOUT
  } mon_state_t;

endpackage

// File: rtl/lfsr_period_monitor.sv
// Measures the recurrence period of an LFSR state bus and its bit-0 balance,
// flagging all-zero lockup and failure to recur within 2^WIDTH cycles.
module lfsr_period_monitor
  import lfsr_pkg::*;
#(
  parameter int WIDTH = LFSR_W,
  parameter int CNT_W = WIDTH + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] state_in,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] ones_count,
  output logic             lockup,
  output logic             timeout
);

  // A maximal-length sequence recurs after at most 2^WIDTH - 1 cycles.
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(1) << WIDTH;

  mon_state_t       state, state_n;
  logic [WIDTH-1:0] ref_state, ref_state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] ones, ones_n;
  logic [CNT_W-1:0] period_n, ones_count_n;
  logic             lockup_n, timeout_n;

  always_ff @(posedge clk) begin
    // NOTE: every register here is reset, including the working copies, so
    // an aborted measurement leaves no stale snapshot behind.
    if (reset) begin
      state      <= IDLE;
      ref_state  <= '0;
      cnt        <= '0;
      ones       <= '0;
      period     <= '0;
      ones_count <= '0;
      lockup     <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values computed by the combinational block.
      state      <= state_n;
      ref_state  <= ref_state_n;
      cnt        <= cnt_n;
      ones       <= ones_n;
      period     <= period_n;
      ones_count <= ones_count_n;
      lockup     <= lockup_n;
      timeout    <= timeout_n;
    end
  end

  always_comb begin
    // NOTE: hold-everything defaults first, so no path through the case
    // leaves a variable unassigned and infers a latch.
    state_n      = state;
    ref_state_n  = ref_state;
    cnt_n        = cnt;
    ones_n       = ones;
    period_n     = period;
    ones_count_n = ones_count;
    lockup_n     = lockup;
    timeout_n    = timeout;

    unique case (state)
      IDLE: begin
        if (start) begin
          ref_state_n  = state_in;
          cnt_n        = CNT_W'(1);
          ones_n       = CNT_W'(state_in[0]);
          period_n     = '0;
          ones_count_n = '0;
          lockup_n     = 1'b0;
          timeout_n    = 1'b0;
          if (state_in == '0) begin
            lockup_n = 1'b1;
            state_n  = LOCKUP;
          end else begin
            state_n = COUNT;
          end
        end
      end

      COUNT: begin
        // Zero check outranks the match so a zero snapshot can never "recur".
        if (state_in == '0) begin
          lockup_n = 1'b1;
          state_n  = LOCKUP;
        end else if (state_in == ref_state) begin
          period_n     = cnt;
          ones_count_n = ones;
          state_n      = DONE;
        end else if (cnt == CNT_LIMIT) begin
          period_n     = '0;
          ones_count_n = '0;
          timeout_n    = 1'b1;
          state_n      = TIMEOUT;
        end else begin
          cnt_n  = cnt + CNT_W'(1);
          ones_n = ones + CNT_W'(state_in[0]);
        end
      end

      DONE, LOCKUP, TIMEOUT: state_n = IDLE;

      default: state_n = IDLE;
    endcase
  end

  assign busy = (state == COUNT);
  assign done = (state == DONE);

endmodule

// File: tb/tb_lfsr_period_monitor.sv
// Directed bench for lfsr_period_monitor at WIDTH=4 with hand-computed expectations.
module tb_lfsr_period_monitor;

  localparam int W  = 4;
  localparam int CW = W + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [W-1:0]  state_in = '0;
  logic          start = 1'b0;
  logic          busy, done, lockup, timeout;
  logic [CW-1:0] period, ones_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] seq [15];

  lfsr_period_monitor #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .state_in  (state_in),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .period    (period),
    .ones_count(ones_count),
    .lockup    (lockup),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Apply inputs at a falling edge; return at the next falling edge, where the
  // outputs reflect the rising edge that sampled them.
  task automatic cycle(input logic [W-1:0] s, input logic st);
    state_in = s;
    start    = st;
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".busy"}, busy, 0);
    check({tag, ".done"}, done, 0);
    check({tag, ".period"}, period, 0);
    check({tag, ".ones"}, ones_count, 0);
    check({tag, ".lockup"}, lockup, 0);
    check({tag, ".timeout"}, timeout, 0);
  endtask

  // Drive the x^4+x^3+1 sequence from 0001 with start on the first cycle.
  // abort_at > 0 asserts reset on that cycle; repulse_at > 0 re-pulses start.
  task automatic run_lfsr(input string tag, input int abort_at, input int repulse_at);
    cycle(seq[0], 1'b1);
    check({tag, ".busy_start"}, busy, 1);
    check({tag, ".period_cleared"}, period, 0);
    for (int j = 1; j <= 15; j++) begin
      if (j == abort_at) begin
        reset = 1'b1;
        cycle(seq[j % 15], 1'b0);
        reset = 1'b0;
        check_all_zero({tag, ".abort"});
        return;
      end
      cycle(seq[j % 15], j == repulse_at);
      if (j == 14) begin
        check({tag, ".done_early"}, done, 0);
        check({tag, ".busy_mid"}, busy, 1);
      end
    end
    check({tag, ".done"}, done, 1);
    check({tag, ".period"}, period, 15);
    check({tag, ".ones"}, ones_count, 8);
    check({tag, ".lockup"}, lockup, 0);
    check({tag, ".timeout"}, timeout, 0);
    check({tag, ".busy_end"}, busy, 0);
    // A start presented during the DONE cycle must be dropped.
    cycle(seq[1], 1'b1);
    check({tag, ".done_pulse_len"}, done, 0);
    check({tag, ".start_in_done"}, busy, 0);
    check({tag, ".period_held"}, period, 15);
    cycle(seq[2], 1'b0);
  endtask

  initial begin
    logic [W-1:0] s;
    s = 4'b0001;
    for (int i = 0; i < 15; i++) begin
      seq[i] = s;
      s = {s[2:0], s[3] ^ s[2]};
    end

    @(negedge clk);
    reset = 1'b1;
    cycle(4'b0000, 1'b0);
    reset = 1'b0;
    check_all_zero("reset");

    run_lfsr("maximal", 0, 0);

    // Constant nonzero state: minimum period of 1.
    cycle(4'b1010, 1'b1);
    check("const.busy", busy, 1);
    check("const.done_early", done, 0);
    cycle(4'b1010, 1'b0);
    check("const.done", done, 1);
    check("const.period", period, 1);
    check("const.ones", ones_count, 0);
    cycle(4'b1010, 1'b0);
    check("const.done_off", done, 0);

    // All-zero state mid-measurement.
    cycle(4'b0011, 1'b1);
    cycle(4'b0110, 1'b0);
    check("lock.busy", busy, 1);
    check("lock.early", lockup, 0);
    cycle(4'b0000, 1'b0);
    check("lock.flag", lockup, 1);
    check("lock.done", done, 0);
    check("lock.busy_off", busy, 0);
    cycle(4'b0000, 1'b0);
    check("lock.sticky", lockup, 1);
    check("lock.idle_busy", busy, 0);
    check("lock.idle_done", done, 0);

    // Never recurs: timeout once the count reaches 16.
    cycle(4'b0101, 1'b1);
    check("tmo.lock_cleared", lockup, 0);
    for (int j = 1; j <= 16; j++) begin
      cycle((j % 2 == 1) ? 4'b0110 : 4'b0111, 1'b0);
      if (j == 15) begin
        check("tmo.early", timeout, 0);
        check("tmo.busy", busy, 1);
      end
    end
    check("tmo.flag", timeout, 1);
    check("tmo.period", period, 0);
    check("tmo.busy_off", busy, 0);
    cycle(4'b0110, 1'b0);
    check("tmo.sticky", timeout, 1);
    check("tmo.done", done, 0);

    run_lfsr("abort", 5, 0);
    run_lfsr("after_abort", 0, 0);
    run_lfsr("repulse", 0, 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
